alu_nbit_seq: RTL and testbench

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

---
 rtl/alu_nbit_seq.sv | 157 +++++++++++++++
 tb/tb_alu_nbit_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: sequential N-bit ALU that waits for late operands and times out.
// Define ALU_MUL_EN to build the MUL_INC/MUL_SHL datapath and its EXEC_MUL state.
module alu_nbit_seq #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ce_i,
  input  logic [1:0]     inp_valid_i,
  input  logic           mode_i,
  input  logic [M-1:0]   cmd_i,
  input  logic           cin_i,
  input  logic [N-1:0]   opa_i,
  input  logic [N-1:0]   opb_i,
  output logic [2*N-1:0] res_o,
  output logic           out_valid_o,
  output logic           cout_o,
  output logic           oflow_o,
  output logic           e_o,
  output logic           g_o,
  output logic           l_o,
  output logic           err_o
);
  localparam int S = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, WAIT, EXEC_MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_q, b_q, a_n, b_n, r;
  logic [M-1:0]   cmd_q, cmd_n;
  logic           mode_q, mode_n, cin_q, cin_n;
  logic [1:0]     got_q, got_n, need;
  logic [S-1:0]   rot;
  logic           co, ov, eq, gt, lt, er;
  logic           accept, ready, is_mul, mul_done, done, tout, fire;
  logic [2*N-1:0] prod, res_d, res_q;
  logic [5:0]     fl_d, fl_q;
  logic           out_valid_q;
  // In WAIT the command is frozen; only operand lanes keep flowing in.
  assign mode_n = state_q == IDLE ? mode_i : mode_q;
  assign cmd_n  = state_q == IDLE ? cmd_i : cmd_q;
  assign cin_n  = state_q == IDLE ? cin_i : cin_q;
  assign got_n  = (state_q == IDLE ? 2'b00 : got_q) | inp_valid_i;
  assign a_n    = inp_valid_i[0] ? opa_i : a_q;
  assign b_n    = inp_valid_i[1] ? opb_i : b_q;
  assign rot    = b_n[S-1:0];
  assign need   = mode_n ? ((cmd_n == M'(4) || cmd_n == M'(5)) ? 2'b01 :
                            (cmd_n == M'(6) || cmd_n == M'(7)) ? 2'b10 : 2'b11)
                         : ((cmd_n == M'(6) || cmd_n == M'(8) || cmd_n == M'(9)) ? 2'b01 :
                            (cmd_n == M'(7) || cmd_n == M'(10) || cmd_n == M'(11)) ? 2'b10 : 2'b11);
  assign ready  = (got_n & need) == need;
  assign accept = state_q == IDLE ? |inp_valid_i : state_q == WAIT;
  assign done   = accept && ready && !is_mul;
  assign tout   = state_q == WAIT && !ready && cnt_q == CW'(TIMEOUT - 1);
  assign fire   = done || tout || mul_done;
`ifdef ALU_MUL_EN
  logic [2*N-1:0] ax, bx;
  assign is_mul   = mode_n && (cmd_n == M'(9) || cmd_n == M'(10));
  assign mul_done = state_q == EXEC_MUL;
  assign ax       = cmd_q[0] ? (2*N)'(a_q) + (2*N)'(1) : (2*N)'({a_q, 1'b0});
  assign bx       = (2*N)'(b_q) + (2*N)'(cmd_q[0]);
  assign prod     = ax * bx;
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign prod     = '0;
`endif
  always_comb begin
    r = '0;
    co = 1'b0;
    ov = 1'b0;
    eq = 1'b0;
    gt = 1'b0;
    lt = 1'b0;
    er = 1'b0;
    if (mode_n)
      case (int'(cmd_n))
        0: {co, r} = {1'b0, a_n} + {1'b0, b_n};
        1: {ov, r} = {1'b0, a_n} - {1'b0, b_n};
        2: {co, r} = {1'b0, a_n} + {1'b0, b_n} + (N+1)'(cin_n);
        3: {ov, r} = {1'b0, a_n} - {1'b0, b_n} - (N+1)'(cin_n);
        4: {co, r} = {1'b0, a_n} + (N+1)'(1);
        5: {ov, r} = {1'b0, a_n} - (N+1)'(1);
        6: {co, r} = {1'b0, b_n} + (N+1)'(1);
        7: {ov, r} = {1'b0, b_n} - (N+1)'(1);
        8: {eq, gt, lt} = {a_n == b_n, a_n > b_n, a_n < b_n};
        default: er = 1'b1;
      endcase
    else
      case (int'(cmd_n))
        0: r = a_n & b_n;
        1: r = ~(a_n & b_n);
        2: r = a_n | b_n;
        3: r = ~(a_n | b_n);
        4: r = a_n ^ b_n;
        5: r = ~(a_n ^ b_n);
        6: r = ~a_n;
        7: r = ~b_n;
        8: r = a_n >> 1;
        9: r = a_n << 1;
        10: r = b_n >> 1;
        11: r = b_n << 1;
        12: if (|(b_n >> S)) er = 1'b1; else r = (a_n << rot) | (a_n >> (N - int'(rot)));
        13: if (|(b_n >> S)) er = 1'b1; else r = (a_n >> rot) | (a_n << (N - int'(rot)));
        default: er = 1'b1;
      endcase
  end
  assign res_d = mul_done ? prod : tout ? '0 : {{N{1'b0}}, r};
  assign fl_d  = (mul_done || tout) ? {5'b0, tout} : {co, ov, eq, gt, lt, er};
  always_comb begin
    state_d = state_q;
    if (fire) state_d = IDLE;
`ifdef ALU_MUL_EN
    else if (accept && ready) state_d = EXEC_MUL;
`endif
    else if (accept) state_d = WAIT;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      got_q       <= '0;
      res_q       <= '0;
      fl_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (ce_i) begin
      state_q     <= state_d;
      cnt_q       <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      out_valid_q <= fire;
      if (accept) begin
        a_q    <= a_n;
        b_q    <= b_n;
        cmd_q  <= cmd_n;
        mode_q <= mode_n;
        cin_q  <= cin_n;
        got_q  <= got_n;
      end
      if (fire) begin
        res_q <= res_d;
        fl_q  <= fl_d;
      end
    end
  assign res_o = res_q;
  assign out_valid_o = out_valid_q;
  assign {cout_o, oflow_o, e_o, g_o, l_o, err_o} = fl_q;
endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: randomized scoreboard bench for alu_nbit_seq against an arithmetic reference model.
module tb_alu_nbit_seq;
  localparam int N = 8, M = 4, TIMEOUT = 16;
  logic clk = 0, rst = 1, ce = 1, mode = 0, cin = 0;
  logic [1:0] inp_valid = 0;
  logic [M-1:0] cmd = 0;
  logic [N-1:0] opa = 0, opb = 0;
  logic [2*N-1:0] res;
  logic out_valid, cout, oflow, e, g, l, err;
  typedef struct { int res; bit [5:0] fl; int lat; int t; } exp_t;
  exp_t q[$];
  exp_t last, px;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit ce_cap = 0, rst_cap = 1;
  always #5 clk = ~clk;
  alu_nbit_seq #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .inp_valid_i(inp_valid), .mode_i(mode),
    .cmd_i(cmd), .cin_i(cin), .opa_i(opa), .opb_i(opb), .res_o(res),
    .out_valid_o(out_valid), .cout_o(cout), .oflow_o(oflow), .e_o(e), .g_o(g),
    .l_o(l), .err_o(err)
  );
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic bit [1:0] need(bit md, int c);
    if (md) return c inside {4, 5} ? 2'b01 : c inside {6, 7} ? 2'b10 : 2'b11;
    return c inside {6, 8, 9} ? 2'b01 : c inside {7, 10, 11} ? 2'b10 : 2'b11;
  endfunction
  function automatic bit is_mul(bit md, int c);
`ifdef ALU_MUL_EN
    return md && c inside {9, 10};
`else
    return 1'b0;
`endif
  endfunction
  function automatic exp_t model(bit md, int c, bit ci, int a, int b);
    exp_t x;
    bit co, ov, eq, gt, lt, er;
    int r;
    x = '{default: 0};
    {co, ov, eq, gt, lt, er} = 6'b0;
    r = 0;
    if (md)
      case (c)
        0: begin r = a + b; co = r > 255; end
        1: begin r = a - b; ov = a < b; end
        2: begin r = a + b + ci; co = r > 255; end
        3: begin r = a - b - ci; ov = a < b + ci; end
        4: begin r = a + 1; co = r > 255; end
        5: begin r = a - 1; ov = a == 0; end
        6: begin r = b + 1; co = r > 255; end
        7: begin r = b - 1; ov = b == 0; end
        8: begin eq = a == b; gt = a > b; lt = a < b; end
`ifdef ALU_MUL_EN
        9: r = (a + 1) * (b + 1);
        10: r = 2 * a * b;
`endif
        default: er = 1;
      endcase
    else
      case (c)
        0: r = a & b;
        1: r = ~(a & b);
        2: r = a | b;
        3: r = ~(a | b);
        4: r = a ^ b;
        5: r = ~(a ^ b);
        6: r = ~a;
        7: r = ~b;
        8: r = a / 2;
        9: r = a * 2;
        10: r = b / 2;
        11: r = b * 2;
        12, 13: if (b > 7) er = 1;
                else begin
                  r = a;
                  repeat (b) r = c == 12 ? ((r * 2) | (r / 128)) & 255 : (r / 2) | ((r % 2) * 128);
                end
        default: er = 1;
      endcase
    x.res = er ? 0 : is_mul(md, c) ? r & 'hFFFF : r & 'hFF;
    x.fl = {co, ov, eq, gt, lt, er};
    return x;
  endfunction
  always @(posedge clk) begin
    cyc++;
    ce_cap = ce;
    rst_cap = rst;
  end
  always @(negedge clk) begin
    if (rst_cap) begin
      chk("reset_res", res, 0);
      chk("reset_flags", {cout, oflow, e, g, l, err}, 0);
      chk("reset_valid", out_valid, 0);
      last = '{default: 0};
    end else if (ce_cap && out_valid) begin
      chk("result_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        px = q.pop_front();
        chk("res", res, px.res);
        chk("flags", {cout, oflow, e, g, l, err}, px.fl);
        chk("latency", cyc - px.t, px.lat);
        last = px;
      end
    end else begin
      chk("hold_res", res, last.res);
      chk("hold_flags", {cout, oflow, e, g, l, err}, last.fl);
      if (ce_cap) chk("valid_low", out_valid, 0);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    inp_valid = 0;
    ce = 1;
  endtask
  task automatic expect_r(exp_t x, int lat);
    x.lat = lat;
    x.t = cyc;
    q.push_back(x);
  endtask
  task automatic txn(bit md, int c, bit ci, int a, int b, bit [1:0] v1, bit tmo, int gap, int bub);
    bit [1:0] v2;
    exp_t x;
    v2 = need(md, c) & ~v1;
    x = model(md, c, ci, a, b);
    ce = 1;
    inp_valid = v1;
    mode = md;
    cmd = M'(c);
    cin = ci;
    opa = v1[0] ? N'(a) : N'($urandom);
    opb = v1[1] ? N'(b) : N'($urandom);
    if (v2 != 0) begin
      if (tmo) begin
        x = '{default: 0};
        x.fl = 6'b000001;
        expect_r(x, TIMEOUT + 1);
        step();
        idle();
        repeat (TIMEOUT) step();
        return;
      end
      step();
      for (int i = 0; i < gap; i++) begin
        inp_valid = 0;
        mode = 1'($urandom);
        cmd = M'($urandom);
        ce = ($urandom % 3) != 0;
        step();
      end
      ce = 1;
      inp_valid = v2;
      mode = 1'($urandom);
      cmd = M'($urandom);
      cin = 1'($urandom);
      opa = v2[0] ? N'(a) : N'($urandom);
      opb = v2[1] ? N'(b) : N'($urandom);
    end
    if (is_mul(md, c)) begin
      expect_r(x, 2 + bub);
      step();
      inp_valid = 2'b11;
      opa = N'($urandom);
      opb = N'($urandom);
      ce = 0;
      repeat (bub) step();
      ce = 1;
      step();
    end else begin
      expect_r(x, 1);
      step();
    end
    idle();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int a, b, c;
    bit md;
    bit [1:0] v1;
    repeat (2) step();
    rst = 0;
    step();
    txn(1, 0, 0, 'hFF, 'h01, 2'b11, 0, 0, 0);
    txn(1, 8, 0, 'h55, 'h55, 2'b11, 0, 0, 0);
    txn(1, 0, 0, 'h12, 'h34, 2'b01, 1, 0, 0);
    txn(1, 1, 0, 'h10, 'h20, 2'b01, 0, 2, 0);
    txn(1, 9, 0, 3, 4, 2'b11, 0, 0, 0);
    txn(1, 10, 0, 'hFF, 'hFF, 2'b11, 0, 0, 2);
    txn(1, 3, 1, 'h20, 'h20, 2'b11, 0, 0, 0);
    txn(1, 5, 0, 0, 0, 2'b01, 0, 0, 0);
    txn(0, 12, 0, 'h81, 3, 2'b11, 0, 0, 0);
    txn(0, 13, 0, 'h81, 1, 2'b10, 0, 3, 0);
    inp_valid = 2'b01;
    mode = 1;
    cmd = 0;
    opa = 8'h44;
    step();
    idle();
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    step();
    txn(0, 12, 0, 'hA5, 'h08, 2'b11, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      md = 1'($urandom);
      c = int'($urandom % 16);
      a = int'($urandom % 256);
      b = int'($urandom % 256);
      if ($urandom % 2) b = b % 8;
      v1 = ($urandom % 4 == 0) ? 2'b11 : 2'(1 + $urandom % 3);
      txn(md, c, 1'($urandom), a, b, v1, $urandom % 16 == 0, int'($urandom % 6), int'($urandom % 3));
      repeat ($urandom % 2) step();
    end
    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
